mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single-port unified memory shared by the instruction-fetch (IF) stage and the load/store (MEM) stage of the pipelined core. It grants one access at a time and tracks the outstanding transaction. When the port is busy it raises stall requests toward the pipeline control. It also discards a fetch response whose instruction was flushed by a taken branch.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified single-port memory shared by instruction fetch
// and load/store. One access outstanding at a time; flushed fetch responses are dropped.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   input  logic              i_ls_req,
   input  logic              i_ls_we,
   input  logic [ADDR_W-1:0] i_ls_addr,
   input  logic [31:0]       i_ls_wdata,
   input  logic [3:0]        i_ls_bmask,
   input  logic              i_flush,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [31:0]       o_mem_wdata,
   output logic [3:0]        o_mem_bmask,
   input  logic              i_mem_rvalid,
   input  logic [31:0]       i_mem_rdata,
   output logic              o_if_valid,
   output logic [31:0]       o_if_rdata,
   output logic              o_ls_valid,
   output logic [31:0]       o_ls_rdata,
   output logic              o_stall_if,
   output logic              o_stall_mem,
   output logic              o_err,
   output logic [1:0]        o_state
);

   // Handshake: a requester holds req high until its valid; the memory answers every
   // o_mem_req with exactly one i_mem_rvalid at least one cycle later.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_LS = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   // Compared against the pre-increment count, so the abort lands TIMEOUT-1 cycles after the grant.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 2);

   state_t     state_q;
   logic       last_ls_q;
   logic [7:0] cnt_q;

   logic idle;
   logic grant_ls;
   logic grant_if;
   logic timeout;

   always_comb begin
      idle     = (state_q == IDLE);
      grant_ls = idle && i_ls_req && (!i_if_req || !last_ls_q || i_flush);
      grant_if = idle && i_if_req && !i_flush && !grant_ls;
      timeout  = !idle && !i_mem_rvalid && (cnt_q == TO_LAST);
   end

   // Everything is held at zero while reset is asserted.
   always_comb begin
      o_mem_req   = i_reset && (grant_ls || grant_if);
      o_mem_we    = i_reset && grant_ls && i_ls_we;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_bmask = '0;
      if (i_reset && grant_ls) begin
         o_mem_addr  = i_ls_addr;
         o_mem_wdata = i_ls_wdata;
         o_mem_bmask = i_ls_bmask;
      end else if (i_reset && grant_if) begin
         o_mem_addr = i_if_addr;
      end
      o_if_valid  = i_reset && (state_q == BUSY_IF) && i_mem_rvalid && !i_flush;
      o_ls_valid  = i_reset && (state_q == BUSY_LS) && i_mem_rvalid;
      o_if_rdata  = o_if_valid ? i_mem_rdata : 32'd0;
      o_ls_rdata  = o_ls_valid ? i_mem_rdata : 32'd0;
      o_stall_if  = i_reset && i_if_req && !o_if_valid;
      o_stall_mem = i_reset && i_ls_req && !o_ls_valid;
      o_err       = i_reset && timeout;
      o_state     = i_reset ? state_q : IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q   <= IDLE;
         last_ls_q <= 1'b0;
         cnt_q     <= 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_ls || grant_if) begin
                  state_q   <= grant_ls ? BUSY_LS : BUSY_IF;
                  last_ls_q <= grant_ls;
                  cnt_q     <= 8'd0;
               end
            end
            BUSY_IF: begin
               if (i_mem_rvalid || timeout) begin
                  state_q <= IDLE;
               end else begin
                  if (i_flush) state_q <= DRAIN;
                  if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
               end
            end
            BUSY_LS, DRAIN: begin
               if (i_mem_rvalid || timeout) begin
                  state_q <= IDLE;
               end else if (cnt_q != 8'hFF) begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, flush, store, timeout, reset.
module tb_mem_port_arbiter;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        i_ls_req;
   logic        i_ls_we;
   logic [31:0] i_ls_addr;
   logic [31:0] i_ls_wdata;
   logic [3:0]  i_ls_bmask;
   logic        i_flush;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [3:0]  o_mem_bmask;
   logic        i_mem_rvalid;
   logic [31:0] i_mem_rdata;
   logic        o_if_valid;
   logic [31:0] o_if_rdata;
   logic        o_ls_valid;
   logic [31:0] o_ls_rdata;
   logic        o_stall_if;
   logic        o_stall_mem;
   logic        o_err;
   logic [1:0]  o_state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(16)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
      .i_ls_wdata(i_ls_wdata), .i_ls_bmask(i_ls_bmask), .i_flush(i_flush),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_mem_bmask(o_mem_bmask),
      .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
      .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata),
      .o_ls_valid(o_ls_valid), .o_ls_rdata(o_ls_rdata),
      .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
      .o_err(o_err), .o_state(o_state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
   task automatic next();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr[4];
      exp_addr[0] = 32'h2000; exp_addr[1] = 32'h0200;
      exp_addr[2] = 32'h2000; exp_addr[3] = 32'h0200;

      i_reset = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h0; i_ls_req = 1'b1; i_ls_we = 1'b0;
      i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_ls_bmask = 4'h0; i_flush = 1'b0;
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
      next();
      settle();
      chk("rst_mem_req", o_mem_req, 0);
      chk("rst_stall_if", o_stall_if, 0);
      chk("rst_stall_mem", o_stall_mem, 0);
      chk("rst_state", o_state, 0);
      next();

      // Single fetch, latency 1
      i_reset = 1'b1; i_ls_req = 1'b0; i_mem_rvalid = 1'b0; i_if_addr = 32'h100;
      settle();
      chk("f1_mem_req", o_mem_req, 1);
      chk("f1_addr", o_mem_addr, 32'h100);
      chk("f1_we", o_mem_we, 0);
      chk("f1_stall_c0", o_stall_if, 1);
      next();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEADBEEF;
      settle();
      chk("f1_valid", o_if_valid, 1);
      chk("f1_rdata", o_if_rdata, 32'hDEADBEEF);
      chk("f1_stall_c1", o_stall_if, 0);
      chk("f1_no_req_busy", o_mem_req, 0);
      next();
      i_if_req = 1'b0; i_mem_rvalid = 1'b0;
      settle();
      chk("idle_state", o_state, 0);
      next();

      // Contention, latency 2: LS, IF, LS, IF at cycles 0,3,6,9
      i_if_req = 1'b1; i_if_addr = 32'h200; i_ls_req = 1'b1; i_ls_addr = 32'h2000;
      for (int g = 0; g < 4; g++) begin
         i_mem_rvalid = 1'b0;
         settle();
         chk("ct_req", o_mem_req, 1);
         chk("ct_addr", o_mem_addr, exp_addr[g]);
         next();
         settle();
         chk("ct_wait_req", o_mem_req, 0);
         chk("ct_wait_state", o_state, (g % 2 == 0) ? 32'd2 : 32'd1);
         next();
         i_mem_rvalid = 1'b1; i_mem_rdata = 32'hA5A50000 + 32'(g);
         settle();
         if (g % 2 == 0) begin
            chk("ct_ls_valid", o_ls_valid, 1);
            chk("ct_ls_rdata", o_ls_rdata, 32'hA5A50000 + 32'(g));
            chk("ct_stall_mem", o_stall_mem, 0);
            chk("ct_stall_if_held", o_stall_if, 1);
         end else begin
            chk("ct_if_valid", o_if_valid, 1);
            chk("ct_if_rdata", o_if_rdata, 32'hA5A50000 + 32'(g));
            chk("ct_stall_if", o_stall_if, 0);
            chk("ct_stall_mem_held", o_stall_mem, 1);
         end
         next();
      end
      i_if_req = 1'b0; i_ls_req = 1'b0; i_mem_rvalid = 1'b0;
      next();

      // Flush in flight, latency 4
      i_if_req = 1'b1; i_if_addr = 32'h300;
      settle();
      chk("fl_req", o_mem_req, 1);
      next();
      i_flush = 1'b1;
      settle();
      chk("fl_valid_p1", o_if_valid, 0);
      next();
      i_flush = 1'b0; i_if_addr = 32'h400;
      settle();
      chk("fl_drain", o_state, 3);
      next();
      next();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BADF00D;
      settle();
      chk("fl_drop_valid", o_if_valid, 0);
      chk("fl_drain_no_req", o_mem_req, 0);
      next();
      i_mem_rvalid = 1'b0;
      settle();
      chk("fl_regrant", o_mem_req, 1);
      chk("fl_regrant_addr", o_mem_addr, 32'h400);
      next();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h44;
      settle();
      chk("fl_refetch_valid", o_if_valid, 1);
      next();
      i_if_req = 1'b0; i_mem_rvalid = 1'b0;
      next();

      // Same-cycle flush and rvalid; pending LSU granted next
      i_if_req = 1'b1; i_if_addr = 32'h500;
      settle();
      chk("sc_if_addr", o_mem_addr, 32'h500);
      next();
      i_mem_rvalid = 1'b1; i_flush = 1'b1; i_ls_req = 1'b1; i_ls_addr = 32'h2100;
      settle();
      chk("sc_no_valid", o_if_valid, 0);
      chk("sc_no_req", o_mem_req, 0);
      next();
      i_mem_rvalid = 1'b0; i_flush = 1'b0; i_if_addr = 32'h600;
      settle();
      chk("sc_ls_grant", o_mem_req, 1);
      chk("sc_ls_addr", o_mem_addr, 32'h2100);
      next();
      i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55;
      settle();
      chk("sc_ls_valid", o_ls_valid, 1);
      next();
      i_mem_rvalid = 1'b0; i_ls_req = 1'b0;
      settle();
      chk("sc_if_after", o_mem_addr, 32'h600);
      next();
      i_mem_rvalid = 1'b1;
      settle();
      chk("sc_if_valid", o_if_valid, 1);
      next();
      i_if_req = 1'b0; i_mem_rvalid = 1'b0;
      next();

      // Store with flush during BUSY_LS
      i_ls_req = 1'b1; i_ls_we = 1'b1; i_ls_addr = 32'h2004;
      i_ls_wdata = 32'h12345678; i_ls_bmask = 4'b0011;
      settle();
      chk("st_req", o_mem_req, 1);
      chk("st_we", o_mem_we, 1);
      chk("st_addr", o_mem_addr, 32'h2004);
      chk("st_wdata", o_mem_wdata, 32'h12345678);
      chk("st_bmask", o_mem_bmask, 4'b0011);
      next();
      i_flush = 1'b1;
      settle();
      chk("st_flush_state", o_state, 2);
      chk("st_no_valid", o_ls_valid, 0);
      next();
      i_mem_rvalid = 1'b1;
      settle();
      chk("st_ack", o_ls_valid, 1);
      chk("st_stall", o_stall_mem, 0);
      next();
      i_ls_req = 1'b0; i_ls_we = 1'b0; i_flush = 1'b0; i_mem_rvalid = 1'b0;
      next();

      // Timeout: memory silent, err 15 cycles after grant, then reissue
      i_ls_req = 1'b1; i_ls_addr = 32'h2200;
      settle();
      chk("to_grant", o_mem_req, 1);
      next();
      for (int k = 1; k < 15; k++) begin
         settle();
         chk("to_no_err", o_err, 0);
         chk("to_no_req", o_mem_req, 0);
         next();
      end
      settle();
      chk("to_err", o_err, 1);
      chk("to_no_valid", o_ls_valid, 0);
      next();
      settle();
      chk("to_err_pulse", o_err, 0);
      chk("to_reissue", o_mem_req, 1);
      chk("to_reissue_addr", o_mem_addr, 32'h2200);
      next();

      // Reset asserted in BUSY_LS
      i_reset = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h700;
      settle();
      chk("rb_mem_req", o_mem_req, 0);
      chk("rb_stall_mem", o_stall_mem, 0);
      chk("rb_stall_if", o_stall_if, 0);
      chk("rb_state_mask", o_state, 0);
      next();
      i_reset = 1'b1; i_if_req = 1'b0; i_ls_req = 1'b0; i_mem_rvalid = 1'b1;
      settle();
      chk("rb_state_idle", o_state, 0);
      chk("rb_late_rvalid", o_ls_valid, 0);
      chk("rb_err", o_err, 0);
      next();
      i_mem_rvalid = 1'b0;
      settle();
      chk("rb_spurious_state", o_state, 0);
      // last_ls was cleared by reset, so the LSU wins contention
      i_if_req = 1'b1; i_ls_req = 1'b1; i_ls_addr = 32'h2300;
      settle();
      chk("rb_lastls_addr", o_mem_addr, 32'h2300);
      next();
      i_if_req = 1'b0; i_ls_req = 1'b0;
      next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
